// File: rtl/rhs_pkg.sv
// Shared definitions for the rhs_256 host-link framing path.
//   - frame packer state encoding
//   - default sync word and scan geometry (chips x channels per scan)
package rhs_pkg;

    localparam int          CHANNELS_PER_CHIP = 16;
    localparam int          CHIP_COUNT        = 16;
    localparam int          SAMPLES_DEF       = CHANNELS_PER_CHIP * CHIP_COUNT;
    localparam logic [15:0] SYNC_WORD_DEF     = 16'hA5C3;
    localparam int          STATE_W           = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_HUNT    = 3'd1,
        ST_HDR     = 3'd2,
        ST_CNT_HI  = 3'd3,
        ST_CNT_LO  = 3'd4,
        ST_PAYLOAD = 3'd5,
        ST_CSUM    = 3'd6
    } state_t;

endpackage

// File: rtl/rhs_sat_counter.sv
// Saturating event counter.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   i_inc      count one event this cycle
//   o_count    current count; holds at all-ones once reached
module rhs_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Only written on a counted event so the value is otherwise held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_count <= '0;
        else if (i_inc && (r_count != {W{1'b1}}))
            r_count <= r_count + 1'b1;
    end

    assign o_count = r_count;

endmodule

// File: rtl/rhs_frame_packer.sv
// Wraps the rhs_256 sample stream into host-link frames:
//   SYNC_WORD, frame_count[31:16], frame_count[15:0],
//   SAMPLES_PER_FRAME payload words, 16-bit XOR checksum (out_last).
// Frames start only on an in_sof sample; samples before one are dropped.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   enable                        1 = produce frames, 0 = stop after current frame
//   in_data/in_sof/in_valid/in_ready   sample stream (valid/ready)
//   out_data/out_valid/out_ready/out_last  frame stream (valid/ready)
//   frame_count                   frames completed since reset (wraps)
//   drop_count                    samples dropped while hunting (saturates)
//   sync_error_count              in_sof seen inside a payload (saturates)
//   busy                          not idle
module rhs_frame_packer
    import rhs_pkg::*;
#(
    parameter int          SAMPLES_PER_FRAME = SAMPLES_DEF,
    parameter logic [15:0] SYNC_WORD         = SYNC_WORD_DEF,
    parameter int          CNT_W             = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] in_data,
    input  logic        in_sof,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [31:0] frame_count,
    output logic [15:0] drop_count,
    output logic [15:0] sync_error_count,
    output logic        busy
);

    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_pcnt;
    logic [15:0]        r_csum;
    logic [31:0]        r_frame_count;

    logic w_in_hs, w_pay_last, w_drop_inc, w_serr_inc, w_sof_hit;

    assign w_in_hs    = in_valid && in_ready;
    assign w_sof_hit  = in_valid && in_sof;
    assign w_pay_last = (r_pcnt == CNT_W'(SAMPLES_PER_FRAME - 1));
    assign w_drop_inc = (r_state == ST_HUNT) && in_valid && !in_sof;
    assign w_serr_inc = (r_state == ST_PAYLOAD) && w_in_hs && in_sof && (r_pcnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Header/checksum words come from registers, so out_data is stable
    // during a stall; payload is a straight pass-through with no bubble.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = 16'h0000;
        case (r_state)
            ST_IDLE: begin
                if (enable) w_next = ST_HUNT;
            end
            ST_HUNT: begin
                // The sof sample is left in place to become payload word 0.
                in_ready = !w_sof_hit;
                if (!enable)        w_next = ST_IDLE;
                else if (w_sof_hit) w_next = ST_HDR;
            end
            ST_HDR: begin
                out_valid = 1'b1;
                out_data  = SYNC_WORD;
                if (out_ready) w_next = ST_CNT_HI;
            end
            ST_CNT_HI: begin
                out_valid = 1'b1;
                out_data  = r_frame_count[31:16];
                if (out_ready) w_next = ST_CNT_LO;
            end
            ST_CNT_LO: begin
                out_valid = 1'b1;
                out_data  = r_frame_count[15:0];
                if (out_ready) w_next = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                out_data  = in_data;
                out_valid = in_valid;
                in_ready  = out_ready;
                if (in_valid && out_ready && w_pay_last) w_next = ST_CSUM;
            end
            ST_CSUM: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_data  = r_csum;
                if (out_ready) begin
                    if (!enable)        w_next = ST_IDLE;
                    else if (w_sof_hit) w_next = ST_HDR;
                    else                w_next = ST_HUNT;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Checksum and payload index restart at every frame boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt <= '0;
            r_csum <= 16'h0000;
        end else if ((r_state == ST_HUNT) && w_sof_hit) begin
            r_pcnt <= '0;
            r_csum <= 16'h0000;
        end else if ((r_state == ST_CSUM) && out_ready) begin
            r_pcnt <= '0;
            r_csum <= 16'h0000;
        end else if ((r_state == ST_PAYLOAD) && w_in_hs) begin
            r_pcnt <= w_pay_last ? '0 : r_pcnt + 1'b1;
            r_csum <= r_csum ^ in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_frame_count <= 32'h0;
        else if ((r_state == ST_CSUM) && out_ready)
            r_frame_count <= r_frame_count + 32'h1;
    end

    rhs_sat_counter #(.W(16)) u_drop_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_drop_inc),
        .o_count (drop_count)
    );

    rhs_sat_counter #(.W(16)) u_serr_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_serr_inc),
        .o_count (sync_error_count)
    );

    assign frame_count = r_frame_count;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_rhs_frame_packer.sv
module tb_rhs_frame_packer;

    localparam int          SPF  = 4;
    localparam logic [15:0] SYNC = 16'hA5C3;

    logic        clk = 1'b0;
    logic        rst, enable, in_sof, in_valid, out_ready;
    logic [15:0] in_data;
    logic        in_ready, out_valid, out_last, busy;
    logic [15:0] out_data, drop_count, sync_error_count;
    logic [31:0] frame_count;

    always #5 clk = ~clk;

    rhs_frame_packer #(.SAMPLES_PER_FRAME(SPF), .SYNC_WORD(SYNC), .CNT_W(13)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .in_data(in_data), .in_sof(in_sof), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .frame_count(frame_count), .drop_count(drop_count),
        .sync_error_count(sync_error_count), .busy(busy)
    );

    int n_vec = 0, n_err = 0;

    // Reference tallies, cumulative since the last reset.
    logic [31:0] m_frames;
    int          m_drops, m_serr;

    logic [16:0] in_q[$];   // {sof, data}
    logic [16:0] exp_q[$];  // {last, data}
    logic [16:0] obs_q[$];

    // Stream-level model: hunt for sof, then frame SPF samples.
    function automatic void model_stream();
        bit          hunting = 1'b1;
        int          idx = 0;
        logic [15:0] cs = 16'h0;
        exp_q.delete();
        foreach (in_q[i]) begin
            if (hunting) begin
                if (in_q[i][16]) begin
                    hunting = 1'b0; idx = 0; cs = 16'h0;
                    exp_q.push_back({1'b0, SYNC});
                    exp_q.push_back({1'b0, m_frames[31:16]});
                    exp_q.push_back({1'b0, m_frames[15:0]});
                end else if (m_drops < 65535) m_drops++;
            end
            if (!hunting) begin
                exp_q.push_back({1'b0, in_q[i][15:0]});
                if (idx > 0 && in_q[i][16] && m_serr < 65535) m_serr++;
                cs = cs ^ in_q[i][15:0];
                idx++;
                if (idx == SPF) begin
                    exp_q.push_back({1'b1, cs});
                    m_frames = m_frames + 32'd1;
                    hunting = 1'b1;
                end
            end
        end
    endfunction

    task automatic push_frame(input int serr_at);
        for (int i = 0; i < SPF; i++)
            in_q.push_back({(i == 0) || (i == serr_at), 16'($urandom)});
    endtask

    task automatic push_junk(input int n);
        for (int i = 0; i < n; i++) in_q.push_back({1'b0, 16'($urandom)});
    endtask

    // Drives in_q and collects output handshakes. rmode: 0 always ready,
    // 1 ready pattern 1,0,0,1, 2 random. en_off_at: drop enable once that
    // many samples are consumed (-1 never). abort_after: stop after that
    // many cycles with inputs left driven (0 = run to completion).
    task automatic run_stream(input int rmode, input bit gaps, input int en_off_at,
                              input int abort_after, output int stall_bad, output int idle_gaps);
        int          ip = 0, cyc = 0, rcnt = 0;
        bit          pres = 1'b0, stall = 1'b0;
        logic [15:0] held = 16'h0;
        stall_bad = 0; idle_gaps = 0;
        obs_q.delete();
        if (abort_after == 0) model_stream();
        while (cyc < 2000) begin
            if (abort_after == 0 && ip >= in_q.size() && obs_q.size() >= exp_q.size()) break;
            if (abort_after != 0 && cyc >= abort_after) break;
            @(negedge clk);
            if (en_off_at >= 0 && ip >= en_off_at) enable = 1'b0;
            if (!pres && ip < in_q.size() && (!gaps || $urandom_range(3) != 0)) pres = 1'b1;
            in_valid = pres;
            {in_sof, in_data} = pres ? in_q[ip] : 17'h0;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (rcnt % 4 == 0) || (rcnt % 4 == 3);
                default: out_ready = 1'($urandom_range(1));
            endcase
            rcnt++;
            #1;
            if (stall && (!out_valid || out_data !== held)) stall_bad++;
            stall = out_valid && !out_ready;
            held  = out_data;
            if (out_valid && out_ready) obs_q.push_back({out_last, out_data});
            if (obs_q.size() > 0 && obs_q.size() < exp_q.size() && !out_valid) idle_gaps++;
            if (in_valid && in_ready) begin ip++; pres = 1'b0; end
            cyc++;
        end
        if (abort_after == 0) begin
            @(posedge clk); #1;
            in_valid = 1'b0; in_sof = 1'b0;
        end
        in_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = 16'h0; out_ready = 1'b0;
        m_frames = 32'h0; m_drops = 0; m_serr = 0;
        repeat (3) @(negedge clk);
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        n_vec++; if (out_data !== 16'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if ({frame_count, drop_count, sync_error_count} !== 64'h0) begin
            n_err++; $display("FAIL reset_counters: got %h/%h/%h want 0", frame_count, drop_count, sync_error_count); end
        @(negedge clk); rst = 1'b0; enable = 1'b1;
    endtask

    task automatic test_directed();
        int          sb, ig;
        logic [16:0] want[8];
        want = '{17'h0A5C3, 17'h00000, 17'h00000, 17'h00007, 17'h00001, 17'h00002, 17'h00003, 17'h10007};
        in_q = '{17'h00002, 17'h00005, 17'h10007, 17'h00001, 17'h00002, 17'h00003};
        run_stream(0, 1'b0, -1, 0, sb, ig);
        n_vec++; if (obs_q.size() !== 8) begin n_err++; $display("FAIL directed_len: got %0d want 8", obs_q.size()); end
        else for (int i = 0; i < 8; i++) begin
            n_vec++; if (obs_q[i] !== want[i]) begin n_err++; $display("FAIL directed_word%0d: got %h want %h", i, obs_q[i], want[i]); end
        end
        n_vec++; if (drop_count !== 16'd2) begin n_err++; $display("FAIL directed_drops: got %0d want 2", drop_count); end
        n_vec++; if (frame_count !== 32'd1) begin n_err++; $display("FAIL directed_frames: got %0d want 1", frame_count); end
    endtask

    // Shared result check used after a completed stream, written out per test.
    task automatic test_back_to_back();
        int sb, ig;
        push_frame(-1); push_frame(-1);
        run_stream(0, 1'b0, -1, 0, sb, ig);
        n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL b2b_len: got %0d want %0d", obs_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_vec++; if (ig !== 0) begin n_err++; $display("FAIL b2b_idle: got %0d idle cycles want 0", ig); end
        n_vec++; if (frame_count !== m_frames) begin n_err++; $display("FAIL b2b_frames: got %0d want %0d", frame_count, m_frames); end
    endtask

    task automatic test_backpressure();
        int sb, ig;
        push_junk(1); push_frame(-1); push_frame(-1);
        run_stream(1, 1'b0, -1, 0, sb, ig);
        n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL bp_len: got %0d want %0d", obs_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_vec++; if (sb !== 0) begin n_err++; $display("FAIL bp_stall_hold: got %0d unstable stalls want 0", sb); end
        n_vec++; if (drop_count !== 16'(m_drops)) begin n_err++; $display("FAIL bp_drops: got %0d want %0d", drop_count, m_drops); end
    endtask

    task automatic test_sync_error();
        int sb, ig;
        push_frame(2);
        run_stream(0, 1'b0, -1, 0, sb, ig);
        n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL serr_len: got %0d want %0d", obs_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL serr_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_vec++; if (sync_error_count !== 16'(m_serr)) begin n_err++; $display("FAIL serr_count: got %0d want %0d", sync_error_count, m_serr); end
    endtask

    task automatic test_random();
        int sb, ig;
        for (int s = 0; s < 6; s++) begin
            push_junk($urandom_range(3));
            for (int f = 0; f < int'($urandom_range(3, 1)); f++) begin
                push_frame(($urandom_range(3) == 0) ? int'($urandom_range(SPF - 1, 1)) : -1);
                push_junk($urandom_range(2));
            end
            run_stream(2, 1'b1, -1, 0, sb, ig);
            n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL rnd%0d_len: got %0d want %0d", s, obs_q.size(), exp_q.size()); end
            else foreach (exp_q[i]) begin
                n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rnd%0d_word%0d: got %h want %h", s, i, obs_q[i], exp_q[i]); end
            end
            n_vec++; if (sb !== 0) begin n_err++; $display("FAIL rnd%0d_stall_hold: got %0d want 0", s, sb); end
            n_vec++; if ({frame_count, drop_count, sync_error_count} !== {m_frames, 16'(m_drops), 16'(m_serr)}) begin
                n_err++; $display("FAIL rnd%0d_counters: got %h/%h/%h want %h/%h/%h", s, frame_count, drop_count,
                                  sync_error_count, m_frames, 16'(m_drops), 16'(m_serr)); end
        end
    endtask

    task automatic test_enable_drop();
        int sb, ig;
        push_frame(-1);
        run_stream(0, 1'b0, 2, 0, sb, ig);
        n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL endrop_len: got %0d want %0d", obs_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL endrop_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        @(negedge clk); in_valid = 1'b1; in_data = 16'h1234; #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL endrop_busy: got %b want 0", busy); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL endrop_in_ready: got %b want 0", in_ready); end
        in_valid = 1'b0; enable = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_rst_mid();
        int sb, ig;
        push_frame(-1);
        run_stream(0, 1'b0, -1, 5, sb, ig);
        n_vec++; if (!(busy === 1'b1 && out_valid === 1'b1)) begin
            n_err++; $display("FAIL rstmid_pre: got busy %b valid %b want 1 1", busy, out_valid); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if ({out_valid, out_last, in_ready, busy, out_data} !== 20'h0) begin
            n_err++; $display("FAIL rstmid_outputs: got v%b l%b r%b b%b d%h want all 0", out_valid, out_last, in_ready, busy, out_data); end
        n_vec++; if ({frame_count, drop_count, sync_error_count} !== 64'h0) begin
            n_err++; $display("FAIL rstmid_counters: got %h/%h/%h want 0", frame_count, drop_count, sync_error_count); end
        in_valid = 1'b0; in_sof = 1'b0;
        m_frames = 32'h0; m_drops = 0; m_serr = 0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int sb, ig;
        @(negedge clk);
        force dut.r_frame_count = 32'hFFFF_FFFF;
        force dut.u_drop_cnt.r_count = 16'hFFFE;
        @(negedge clk);
        release dut.r_frame_count;
        release dut.u_drop_cnt.r_count;
        m_frames = 32'hFFFF_FFFF; m_drops = 16'hFFFE;
        push_junk(3); push_frame(-1);
        run_stream(0, 1'b0, -1, 0, sb, ig);
        n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL wrap_len: got %0d want %0d", obs_q.size(), exp_q.size()); end
        else begin
            n_vec++; if (obs_q[1][15:0] !== 16'hFFFF || obs_q[2][15:0] !== 16'hFFFF) begin
                n_err++; $display("FAIL wrap_hdr: got %h %h want FFFF FFFF", obs_q[1][15:0], obs_q[2][15:0]); end
            foreach (exp_q[i]) begin
                n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL wrap_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
            end
        end
        n_vec++; if (frame_count !== 32'h0) begin n_err++; $display("FAIL wrap_frames: got %h want 00000000", frame_count); end
        n_vec++; if (drop_count !== 16'hFFFF) begin n_err++; $display("FAIL wrap_drop_sat: got %h want FFFF", drop_count); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_sync_error();
        test_random();
        test_enable_drop();
        test_rst_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
